// File: rtl/clk_div_prog_if.sv
// clk_div_prog_if: control/status bundle for clk_div_prog (en, tc_in, mode_in, load_req in; load_ack, clk_out, tick, count out)
interface clk_div_prog_if #(parameter int WIDTH = 18);
  logic             en;
  logic [WIDTH-1:0] tc_in;
  logic             mode_in;
  logic             load_req;
  logic             load_ack;
  logic             clk_out;
  logic             tick;
  logic [WIDTH-1:0] count;
  modport master (output en, tc_in, mode_in, load_req, input load_ack, clk_out, tick, count);
  modport slave (input en, tc_in, mode_in, load_req, output load_ack, clk_out, tick, count);
endinterface

// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable divider; clk, rst (async active-low), bus: en/tc_in/mode_in/load_req in, load_ack/clk_out/tick/count out
module clk_div_prog #(
  parameter int               WIDTH      = 18,
  parameter logic [WIDTH-1:0] DEFAULT_TC = {1'b0, {(WIDTH-1){1'b1}}}
) (
  input logic            clk,
  input logic            rst,
  clk_div_prog_if.slave  bus
);
  logic [WIDTH-1:0] cnt_q, cnt_d, tc_q, tc_d, tc_p_q, tc_p_d;
  logic m_q, m_d, m_p_q, m_p_d, p_q, p_d;
  logic clk_out_q, clk_out_d, tick_q, tick_d, ack_q, ack_d;
  logic wrap, apply;
  always_comb begin
    wrap      = bus.en && (cnt_q == tc_q);
    apply     = p_q && (wrap || !bus.en);
    cnt_d     = (wrap || apply) ? '0 : bus.en ? cnt_q + WIDTH'(1) : cnt_q;
    tc_d      = apply ? tc_p_q : tc_q;
    m_d       = apply ? m_p_q : m_q;
    clk_out_d = (m_q || (apply && m_p_q)) ? 1'b0 : wrap ? ~clk_out_q : clk_out_q;
    tick_d    = wrap;
    ack_d     = apply;
    p_d       = bus.load_req || (p_q && !apply);
    tc_p_d    = bus.load_req ? bus.tc_in : tc_p_q;
    m_p_d     = bus.load_req ? bus.mode_in : m_p_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      tc_q      <= DEFAULT_TC;
      m_q       <= 1'b0;
      p_q       <= 1'b0;
      tc_p_q    <= '0;
      m_p_q     <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      tc_q      <= tc_d;
      m_q       <= m_d;
      p_q       <= p_d;
      tc_p_q    <= tc_p_d;
      m_p_q     <= m_p_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      ack_q     <= ack_d;
    end
  end
  assign bus.count    = cnt_q;
  assign bus.clk_out  = clk_out_q;
  assign bus.tick     = tick_q;
  assign bus.load_ack = ack_q;
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed self-checking bench for clk_div_prog with WIDTH=8
module tb_clk_div_prog;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  int acks = 0;
  clk_div_prog_if #(.WIDTH(8)) bus();
  clk_div_prog #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.load_ack === 1'b1) acks++;
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic load(input logic [7:0] tc, input logic mode);
    bus.tc_in = tc;
    bus.mode_in = mode;
    bus.load_req = 1'b1;
    step(1);
    bus.load_req = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b0;
    bus.en = 1'b0;
    bus.load_req = 1'b0;
    bus.tc_in = '0;
    bus.mode_in = 1'b0;
    step(2);
    checks++; if ({bus.count, bus.clk_out, bus.tick, bus.load_ack} !== 11'h000) begin failures++; $display("FAIL reset_outputs got=%h exp=000", {bus.count, bus.clk_out, bus.tick, bus.load_ack}); end
    rst = 1'b1;
    step(1);
    checks++; if (bus.count !== 8'd0) begin failures++; $display("FAIL reset_en0_hold got=%0d exp=0", bus.count); end
  endtask
  task automatic test_default;
    bus.en = 1'b1;
    step(127);
    checks++; if ({bus.count, bus.clk_out, bus.tick} !== {8'd127, 2'b00}) begin failures++; $display("FAIL default_pre_wrap got=%h exp=%h", {bus.count, bus.clk_out, bus.tick}, {8'd127, 2'b00}); end
    step(1);
    checks++; if ({bus.count, bus.clk_out, bus.tick} !== {8'd0, 2'b11}) begin failures++; $display("FAIL default_first_wrap got=%h exp=%h", {bus.count, bus.clk_out, bus.tick}, {8'd0, 2'b11}); end
    step(1);
    checks++; if ({bus.count, bus.tick} !== {8'd1, 1'b0}) begin failures++; $display("FAIL default_tick_one_cycle got=%h exp=%h", {bus.count, bus.tick}, {8'd1, 1'b0}); end
    step(126);
    checks++; if ({bus.count, bus.clk_out} !== {8'd127, 1'b1}) begin failures++; $display("FAIL default_high_phase got=%h exp=%h", {bus.count, bus.clk_out}, {8'd127, 1'b1}); end
    step(1);
    checks++; if ({bus.count, bus.clk_out, bus.tick} !== {8'd0, 2'b01}) begin failures++; $display("FAIL default_second_wrap got=%h exp=%h", {bus.count, bus.clk_out, bus.tick}, {8'd0, 2'b01}); end
  endtask
  task automatic test_load_at_wrap;
    int a0;
    step(10);
    a0 = acks;
    load(8'd4, 1'b0);
    checks++; if ({bus.count, bus.load_ack} !== {8'd11, 1'b0}) begin failures++; $display("FAIL load_pending_no_effect got=%h exp=%h", {bus.count, bus.load_ack}, {8'd11, 1'b0}); end
    step(116);
    checks++; if ({bus.count, bus.clk_out, bus.load_ack} !== {8'd127, 2'b00}) begin failures++; $display("FAIL load_wait_wrap got=%h exp=%h", {bus.count, bus.clk_out, bus.load_ack}, {8'd127, 2'b00}); end
    step(1);
    checks++; if ({bus.count, bus.clk_out, bus.tick, bus.load_ack} !== {8'd0, 3'b111}) begin failures++; $display("FAIL load_apply got=%h exp=%h", {bus.count, bus.clk_out, bus.tick, bus.load_ack}, {8'd0, 3'b111}); end
    step(1);
    checks++; if ({bus.count, bus.load_ack} !== {8'd1, 1'b0}) begin failures++; $display("FAIL load_ack_single got=%h exp=%h", {bus.count, bus.load_ack}, {8'd1, 1'b0}); end
    step(3);
    checks++; if ({bus.count, bus.clk_out} !== {8'd4, 1'b1}) begin failures++; $display("FAIL load_new_tc_top got=%h exp=%h", {bus.count, bus.clk_out}, {8'd4, 1'b1}); end
    step(1);
    checks++; if ({bus.count, bus.clk_out, bus.tick} !== {8'd0, 2'b01}) begin failures++; $display("FAIL load_new_tc_wrap got=%h exp=%h", {bus.count, bus.clk_out, bus.tick}, {8'd0, 2'b01}); end
    step(5);
    checks++; if ({bus.count, bus.clk_out} !== {8'd0, 1'b1}) begin failures++; $display("FAIL load_period10 got=%h exp=%h", {bus.count, bus.clk_out}, {8'd0, 1'b1}); end
    checks++; if (acks - a0 !== 1) begin failures++; $display("FAIL load_ack_count got=%0d exp=1", acks - a0); end
  endtask
  task automatic test_tick_mode;
    logic [7:0] e;
    load(8'd2, 1'b1);
    step(4);
    checks++; if ({bus.count, bus.clk_out, bus.tick, bus.load_ack} !== {8'd0, 3'b011}) begin failures++; $display("FAIL tick_apply got=%h exp=%h", {bus.count, bus.clk_out, bus.tick, bus.load_ack}, {8'd0, 3'b011}); end
    for (int i = 0; i < 6; i++) begin
      step(1);
      e = 8'((i + 1) % 3);
      checks++; if ({bus.count, bus.tick, bus.clk_out} !== {e, e == 8'd0, 1'b0}) begin failures++; $display("FAIL tick_seq%0d got=%h exp=%h", i, {bus.count, bus.tick, bus.clk_out}, {e, e == 8'd0, 1'b0}); end
    end
  endtask
  task automatic test_back_to_back;
    int a0;
    a0 = acks;
    load(8'd5, 1'b0);
    load(8'd9, 1'b0);
    checks++; if ({bus.count, bus.load_ack} !== {8'd2, 1'b0}) begin failures++; $display("FAIL b2b_pending got=%h exp=%h", {bus.count, bus.load_ack}, {8'd2, 1'b0}); end
    step(1);
    checks++; if ({bus.count, bus.clk_out, bus.tick, bus.load_ack} !== {8'd0, 3'b011}) begin failures++; $display("FAIL b2b_apply got=%h exp=%h", {bus.count, bus.clk_out, bus.tick, bus.load_ack}, {8'd0, 3'b011}); end
    step(9);
    checks++; if ({bus.count, bus.clk_out} !== {8'd9, 1'b0}) begin failures++; $display("FAIL b2b_last_wins got=%h exp=%h", {bus.count, bus.clk_out}, {8'd9, 1'b0}); end
    step(1);
    checks++; if ({bus.count, bus.clk_out, bus.tick} !== {8'd0, 2'b11}) begin failures++; $display("FAIL b2b_wrap got=%h exp=%h", {bus.count, bus.clk_out, bus.tick}, {8'd0, 2'b11}); end
    step(10);
    checks++; if ({bus.count, bus.clk_out, bus.tick} !== {8'd0, 2'b01}) begin failures++; $display("FAIL b2b_period10 got=%h exp=%h", {bus.count, bus.clk_out, bus.tick}, {8'd0, 2'b01}); end
    checks++; if (acks - a0 !== 1) begin failures++; $display("FAIL b2b_ack_count got=%0d exp=1", acks - a0); end
  endtask
  task automatic test_freeze;
    step(13);
    bus.en = 1'b0;
    step(20);
    checks++; if ({bus.count, bus.clk_out, bus.tick} !== {8'd3, 2'b10}) begin failures++; $display("FAIL freeze_hold got=%h exp=%h", {bus.count, bus.clk_out, bus.tick}, {8'd3, 2'b10}); end
    load(8'd6, 1'b0);
    checks++; if ({bus.count, bus.load_ack} !== {8'd3, 1'b0}) begin failures++; $display("FAIL freeze_load_req got=%h exp=%h", {bus.count, bus.load_ack}, {8'd3, 1'b0}); end
    step(1);
    checks++; if ({bus.count, bus.clk_out, bus.tick, bus.load_ack} !== {8'd0, 3'b101}) begin failures++; $display("FAIL freeze_apply got=%h exp=%h", {bus.count, bus.clk_out, bus.tick, bus.load_ack}, {8'd0, 3'b101}); end
    step(1);
    checks++; if ({bus.count, bus.load_ack} !== {8'd0, 1'b0}) begin failures++; $display("FAIL freeze_ack_once got=%h exp=%h", {bus.count, bus.load_ack}, {8'd0, 1'b0}); end
    bus.en = 1'b1;
    step(6);
    checks++; if ({bus.count, bus.clk_out} !== {8'd6, 1'b1}) begin failures++; $display("FAIL freeze_new_tc got=%h exp=%h", {bus.count, bus.clk_out}, {8'd6, 1'b1}); end
    step(1);
    checks++; if ({bus.count, bus.clk_out, bus.tick} !== {8'd0, 2'b01}) begin failures++; $display("FAIL freeze_new_wrap got=%h exp=%h", {bus.count, bus.clk_out, bus.tick}, {8'd0, 2'b01}); end
  endtask
  task automatic test_reset_pending;
    int a0;
    step(7);
    load(8'd3, 1'b1);
    checks++; if ({bus.count, bus.clk_out} !== {8'd1, 1'b1}) begin failures++; $display("FAIL rstp_before got=%h exp=%h", {bus.count, bus.clk_out}, {8'd1, 1'b1}); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({bus.count, bus.clk_out, bus.tick, bus.load_ack} !== 11'h000) begin failures++; $display("FAIL rstp_async got=%h exp=000", {bus.count, bus.clk_out, bus.tick, bus.load_ack}); end
    a0 = acks;
    step(1);
    rst = 1'b1;
    step(127);
    checks++; if ({bus.count, bus.clk_out, bus.load_ack} !== {8'd127, 2'b00}) begin failures++; $display("FAIL rstp_default_tc got=%h exp=%h", {bus.count, bus.clk_out, bus.load_ack}, {8'd127, 2'b00}); end
    step(1);
    checks++; if ({bus.count, bus.clk_out, bus.tick} !== {8'd0, 2'b11}) begin failures++; $display("FAIL rstp_wrap got=%h exp=%h", {bus.count, bus.clk_out, bus.tick}, {8'd0, 2'b11}); end
    step(1);
    checks++; if (acks !== a0) begin failures++; $display("FAIL rstp_no_ack got=%0d exp=%0d", acks, a0); end
  endtask
  task automatic test_tc_zero;
    logic e;
    bus.en = 1'b0;
    load(8'd0, 1'b0);
    step(1);
    checks++; if ({bus.count, bus.clk_out, bus.load_ack} !== {8'd0, 2'b11}) begin failures++; $display("FAIL tc0_apply got=%h exp=%h", {bus.count, bus.clk_out, bus.load_ack}, {8'd0, 2'b11}); end
    bus.en = 1'b1;
    e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      e = ~e;
      checks++; if ({bus.clk_out, bus.tick, bus.count} !== {e, 1'b1, 8'd0}) begin failures++; $display("FAIL tc0_square%0d got=%h exp=%h", i, {bus.clk_out, bus.tick, bus.count}, {e, 1'b1, 8'd0}); end
    end
    load(8'd0, 1'b1);
    checks++; if ({bus.clk_out, bus.load_ack} !== 2'b10) begin failures++; $display("FAIL tc0_toggle_before got=%b exp=10", {bus.clk_out, bus.load_ack}); end
    step(1);
    checks++; if ({bus.clk_out, bus.tick, bus.load_ack} !== 3'b011) begin failures++; $display("FAIL tc0_tick_apply got=%b exp=011", {bus.clk_out, bus.tick, bus.load_ack}); end
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++; if ({bus.clk_out, bus.tick, bus.load_ack} !== 3'b010) begin failures++; $display("FAIL tc0_tick%0d got=%b exp=010", i, {bus.clk_out, bus.tick, bus.load_ack}); end
    end
  endtask
  initial begin
    test_reset;
    test_default;
    test_load_at_wrap;
    test_tick_mode;
    test_back_to_back;
    test_freeze;
    test_reset_pending;
    test_tc_zero;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
